ex_mdu_ctrl: RTL and testbench
==============================

# ex_mdu_ctrl

Multi-cycle multiply/divide sequencer beside the EX stage ALU. It accepts an MDU operation from the ID/EX pipeline register and runs a 32-iteration radix-2 shift-add multiply or restoring divide. While the operation runs, it raises a stall request to the pipeline controller. It then presents the 32-bit result for one EX/MEM capture. The single-cycle ALU and the EX/MEM register are unchanged; the EX result mux selects `md_out` when `md_valid` is high.

## Interface
- `DATA_W`, 32: operand/result width; iteration count equals `DATA_W`.
- `CNT_W`, 6: iteration counter width; must satisfy 2^CNT_W > DATA_W.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous and active-high; sampled on rising `clk`.
- `stall` in 1: pipeline stall from the pipeline controller (EX/MEM hold).
- `flush` in 1: pipeline flush; the in-flight MDU operation is discarded.
- `id_en` in 1: ID/EX pipeline data valid.
- `id_md_op` in 2: operation code. 00 none, 01 MUL (low word of unsigned product), 10 DIVU (quotient), 11 REMU (remainder).
- `id_alu_in_0` in DATA_W: operand A (multiplicand / dividend).
- `id_alu_in_1` in DATA_W: operand B (multiplier / divisor).
- `md_stall_req` out 1: stall request to the pipeline controller.
- `md_valid` out 1: `md_out` holds a finished result this cycle.
- `md_out` out DATA_W: result.
- `md_busy` out 1: state is not IDLE (status/debug).

## Operation
- `start = (state==IDLE) & id_en & (id_md_op!=00) & ~flush`.
- `md_stall_req = start | (state==CALC)`. This path is combinational, so the first cycle stalls.
- **IDLE**
  - On `start`: latch op, A and B.
  - On `start` with DIVU/REMU and B==0: load the result directly and go to DONE.
  - Otherwise on `start`: clear counter and accumulator; for division, clear the 33-bit partial remainder; go to CALC.
- **CALC**, one iteration per cycle:
  - MUL: if multiplier[0], acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1. Arithmetic is mod 2^DATA_W and overflow is dropped.
  - DIV: rem = {rem[DATA_W-1:0], dividend[MSB]} and dividend <<= 1. If rem >= divisor, then rem -= divisor and shift 1 into the quotient; else shift 0.
  - Counter increments each cycle. When the counter == DATA_W-1, go to DONE.
- **DONE**
  - `md_valid`=1, `md_stall_req`=0.
  - `md_out` = acc (MUL), quotient (DIVU) or remainder (REMU).
  - If `stall`=1, remain in DONE with the result held. Otherwise go to IDLE.
  - No restart is possible in DONE, even though ID/EX still shows the same instruction.
- **Divide by zero:** DIVU returns all ones; REMU returns A.
- **Flush:** `flush`=1 in any state forces IDLE next cycle and discards datapath state. `md_valid` and `md_stall_req` are low in the cycle after the flush. `start` is suppressed while `flush`=1.
- **Reset:** `reset`=1 forces IDLE and zeroes every register, including in mid-operation. Reset takes priority over flush and stall.
- **Reset values:** `md_stall_req`=0, `md_valid`=0, `md_out`=0, `md_busy`=0.
- `md_out` equals 0 outside DONE, so no stale data reaches the EX mux.

## Timing
- T0: IDLE, `start`=1, `md_stall_req`=1; operands latched at the end of T0.
- T1..T32: CALC, `md_stall_req`=1, counter 0..31.
- T33: DONE, `md_valid`=1, `md_stall_req`=0. EX/MEM captures `md_out` at the end of T33 if `stall`=0.
- Total latency is 33 cycles from the start cycle to valid. `md_stall_req` is high for exactly 33 cycles.
- Divide by zero: T0 start, T1 DONE (latency 1).
- Back-to-back MDU instructions: the second `start` is no earlier than T34, with IDLE seen for one cycle.
- `stall` during CALC has no effect; the iteration continues.

## Test plan
- MUL A=7, B=6 at T0 → `md_stall_req` high T0..T32; T33 `md_valid`=1, `md_out`=0x0000002A.
- MUL A=0xFFFFFFFF, B=2 → T33 `md_out`=0xFFFFFFFE. DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002.
- DIVU A=5, B=0 → T1 `md_valid`=1, `md_out`=0xFFFFFFFF; REMU A=5, B=0 → T1 `md_out`=0x00000005.
- `flush` at T10 of a DIVU → T11 IDLE, `md_stall_req`=0, `md_valid` never rises. A new MUL 3×3 at T12 → `md_out`=9 at T45.
- `stall`=1 for T33..T35 in DONE → `md_valid`=1 and `md_out` stable through T35; IDLE at T36; no restart on the held instruction.
- `reset` asserted at T20 of a MUL → next cycle all outputs 0 and state IDLE. A DIVU 0xFFFFFFFF/0x10 after reset → 0x0FFFFFFF at 33 cycles.

Source files
------------

// File: rtl/ex_mdu_ctrl.sv
// rtl/ex_mdu_ctrl.sv - multi-cycle shift-add multiply / restoring divide sequencer beside the EX ALU
module ex_mdu_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_en,
  input  logic [1:0]        id_md_op,
  input  logic [DATA_W-1:0] id_alu_in_0,
  input  logic [DATA_W-1:0] id_alu_in_1,
  output logic              md_stall_req,
  output logic              md_valid,
  output logic [DATA_W-1:0] md_out,
  output logic              md_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;

  state_t            state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] quo;
  // Stored remainder is always below the divisor, so DATA_W bits suffice;
  // the full DATA_W+1 bit partial remainder only exists as rem_sh.
  logic [DATA_W-1:0] rem;
  logic [CNT_W-1:0]  cnt;
  logic              valid_q;
  logic [DATA_W-1:0] out_q;

  logic              start;
  logic              div_zero;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W:0]   rem_sh;
  logic              rem_ge;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic              last;
  logic [DATA_W-1:0] result_fin;

  // Start decode, stall request and one iteration of the multiply/divide datapath
  always_comb begin
    start      = (state == S_IDLE) && id_en && (id_md_op != 2'b00) && !flush;
    div_zero   = id_md_op[1] && (id_alu_in_1 == '0);
    acc_nxt    = acc + (mplier[0] ? mcand : '0);
    rem_sh     = {rem, dvd[DATA_W-1]};
    rem_ge     = (rem_sh >= {1'b0, dvs});
    rem_nxt    = rem_ge ? (rem_sh[DATA_W-1:0] - dvs) : rem_sh[DATA_W-1:0];
    quo_nxt    = (quo << 1) | DATA_W'(rem_ge);
    last       = (cnt == CNT_W'(DATA_W - 1));
    result_fin = rem_nxt;
    if (op_q == OP_MUL) begin
      result_fin = acc_nxt;
    end else if (op_q == OP_DIVU) begin
      result_fin = quo_nxt;
    end
  end

  assign md_stall_req = start || (state == S_CALC);
  assign md_valid     = valid_q;
  assign md_out       = out_q;
  assign md_busy      = (state != S_IDLE);

  // Sequencer FSM with datapath registers and registered result/valid
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state   <= S_IDLE;
      op_q    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= id_md_op;
            mcand  <= id_alu_in_0;
            mplier <= id_alu_in_1;
            dvd    <= id_alu_in_0;
            dvs    <= id_alu_in_1;
            acc    <= '0;
            quo    <= '0;
            rem    <= '0;
            cnt    <= '0;
            if (div_zero) begin
              // Divide by zero short-circuits: quotient all ones, remainder = dividend
              state   <= S_DONE;
              valid_q <= 1'b1;
              out_q   <= (id_md_op == OP_DIVU) ? '1 : id_alu_in_0;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_q == OP_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            rem <= rem_nxt;
            dvd <= dvd << 1;
            quo <= quo_nxt;
          end
          if (last) begin
            state   <= S_DONE;
            valid_q <= 1'b1;
            out_q   <= result_fin;
          end
        end
        S_DONE: begin
          // Hold the result while EX/MEM is stalled; never restart from here
          if (!stall) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            out_q   <= '0;
          end
        end
        default: begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
          out_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// tb/tb_ex_mdu_ctrl.sv - self-checking bench for ex_mdu_ctrl against an arithmetic reference model
module tb_ex_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_en = 1'b0;
  logic [1:0]  id_md_op = 2'b00;
  logic [31:0] id_alu_in_0 = '0;
  logic [31:0] id_alu_in_1 = '0;
  logic        md_stall_req;
  logic        md_valid;
  logic [31:0] md_out;
  logic        md_busy;

  int total = 0;
  int bad = 0;

  ex_mdu_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .id_en        (id_en),
    .id_md_op     (id_md_op),
    .id_alu_in_0  (id_alu_in_0),
    .id_alu_in_1  (id_alu_in_1),
    .md_stall_req (md_stall_req),
    .md_valid     (md_valid),
    .md_out       (md_out),
    .md_busy      (md_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b01: begin p = 64'(a) * 64'(b); return p[31:0]; end
      2'b10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one op at the next negedge (T0), hold ID/EX until capture, stall DONE for 'hold' cycles.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int exp_lat, lat, nstall;
    bit got;
    exp = ref_result(op, a, b);
    exp_lat = (op != 2'b01 && b == 0) ? 1 : 33;
    @(negedge clk);
    id_en = 1'b1; id_md_op = op; id_alu_in_0 = a; id_alu_in_1 = b;
    stall = (hold != 0);
    #1;
    chk(32'(md_stall_req), 32'd1, "t0_stall_req");
    chk(32'(md_valid), 32'd0, "t0_valid");
    nstall = 1; lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(negedge clk); #1;
      lat++;
      if (md_valid) got = 1;
      else begin
        if (md_stall_req) nstall++;
        if (lat == 1) begin
          chk(32'(md_busy), 32'd1, "calc_busy");
          chk(md_out, 32'd0, "calc_out_zero");
        end
      end
    end
    chk(32'(lat), 32'(exp_lat), "latency");
    chk(32'(nstall), 32'(exp_lat), "stall_req_cycles");
    chk(32'(md_stall_req), 32'd0, "done_stall_req");
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk(32'(md_valid), 32'd1, "done_valid");
      chk(md_out, exp, "result");
      stall = (k < hold);
      id_en = (k < hold);
    end
    @(negedge clk); #1;
    chk(32'(md_busy), 32'd0, "idle_after_done");
    chk(32'(md_valid), 32'd0, "idle_valid");
    chk(md_out, 32'd0, "idle_out_zero");
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    // Reset values
    repeat (2) @(negedge clk);
    chk(32'(md_stall_req), 32'd0, "rst_stall_req");
    chk(32'(md_valid), 32'd0, "rst_valid");
    chk(md_out, 32'd0, "rst_out");
    chk(32'(md_busy), 32'd0, "rst_busy");
    reset = 1'b0;

    // Directed cases
    do_op(2'b01, 32'd7, 32'd6, 0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0);
    do_op(2'b10, 32'd100, 32'd7, 0);
    do_op(2'b11, 32'd100, 32'd7, 0);
    do_op(2'b10, 32'd5, 32'd0, 0);
    do_op(2'b11, 32'd5, 32'd0, 0);
    do_op(2'b01, 32'd12345, 32'd678, 2);

    // Flush at T10 of a DIVU, then MUL 3x3 at T12
    @(negedge clk);
    id_en = 1'b1; id_md_op = 2'b10; id_alu_in_0 = 32'd1000; id_alu_in_1 = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1; id_en = 1'b0;
    @(negedge clk);
    flush = 1'b0; #1;
    chk(32'(md_busy), 32'd0, "flush_idle");
    chk(32'(md_stall_req), 32'd0, "flush_stall_req");
    chk(32'(md_valid), 32'd0, "flush_valid");
    do_op(2'b01, 32'd3, 32'd3, 0);

    // Reset at T20 of a MUL
    @(negedge clk);
    id_en = 1'b1; id_md_op = 2'b01; id_alu_in_0 = 32'hDEAD_BEEF; id_alu_in_1 = 32'h1234_5678;
    repeat (20) @(negedge clk);
    reset = 1'b1; id_en = 1'b0;
    @(negedge clk);
    reset = 1'b0; #1;
    chk(32'(md_busy), 32'd0, "midrst_busy");
    chk(32'(md_stall_req), 32'd0, "midrst_stall_req");
    chk(32'(md_valid), 32'd0, "midrst_valid");
    chk(md_out, 32'd0, "midrst_out");
    do_op(2'b10, 32'hFFFF_FFFF, 32'h10, 0);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(1, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0 ? 32'($urandom_range(1, 255)) : $urandom);
      do_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
